// File: rtl/cpu_trace_buffer.sv
// CPU trace capture FIFO with a valid/ready word serializer (4 words per record).
// Define TRACE_TIMESTAMP_EN to store a free-running cycle count per record and emit it as a 5th word.
module cpu_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_en,
   input  logic                     trace_valid,
   input  logic [31:0]              trace_pc,
   input  logic [31:0]              trace_inst,
   input  logic [31:0]              trace_alu,
   input  logic                     trace_zero,
   input  logic                     clr_stats,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic                     out_last,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      W_PC    = 3'd1,
      W_INST  = 3'd2,
      W_ALU   = 3'd3,
      W_FLAGS = 3'd4,
      W_TS    = 3'd5
   } state_e;

`ifdef TRACE_TIMESTAMP_EN
   localparam state_e LAST_ST = W_TS;
`else
   localparam state_e LAST_ST = W_FLAGS;
`endif

   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      inst_mem [DEPTH];
   logic [31:0]      alu_mem  [DEPTH];
   logic             zero_mem [DEPTH];
   logic             povf_mem [DEPTH];
   logic [CNT_W-1:0] seq_mem  [DEPTH];

   state_e           state_q, state_d;
   logic [LW-1:0]    level_q, level_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] seq_q, seq_d;
   logic             pend_ovf_q, pend_ovf_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             overflow_q, overflow_d;

   logic             capture, full, push, drop, pop;
   logic [CNT_W-1:0] drop_base;
   logic [15:0]      seq16;
   logic [31:0]      ts_word;
   state_e           next_rec;

   // Fullness is judged on the pre-edge level, so a same-cycle pop never makes room.
   assign capture = trace_en && trace_valid;
   assign full    = (level_q == LW'(DEPTH));
   assign push    = capture && !full;
   assign drop    = capture && full;
   assign pop     = (state_q == LAST_ST) && out_ready;
   assign level_d = level_q + LW'(push) - LW'(pop);

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] ts_q;
   logic [31:0] ts_mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts_q <= 32'd0;
      else     ts_q <= ts_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (push) ts_mem[wr_ptr_q] <= ts_q;
   end

   assign ts_word = ts_mem[rd_ptr_q];
`else
   assign ts_word = 32'd0;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= trace_pc;
         inst_mem[wr_ptr_q] <= trace_inst;
         alu_mem[wr_ptr_q]  <= trace_alu;
         zero_mem[wr_ptr_q] <= trace_zero;
         povf_mem[wr_ptr_q] <= pend_ovf_q;
         seq_mem[wr_ptr_q]  <= seq_q;
      end
   end

   always_comb begin
      seq_d      = seq_q;
      pend_ovf_d = pend_ovf_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      drop_base  = clr_stats ? '0 : drop_cnt_q;
      drop_cnt_d = drop_base;
      if (clr_stats) overflow_d = 1'b0;
      if (push) begin
         wr_ptr_d   = wr_ptr_q + AW'(1);
         seq_d      = seq_q + CNT_W'(1);
         pend_ovf_d = 1'b0;
      end
      // A drop on the clearing edge still counts, leaving the stats at one drop.
      if (drop) begin
         drop_cnt_d = (drop_base == '1) ? drop_base : drop_base + CNT_W'(1);
         overflow_d = 1'b1;
         pend_ovf_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_comb begin
      next_rec = (level_d != '0) ? W_PC : IDLE;
      state_d  = state_q;
      unique case (state_q)
         IDLE:    if (level_q != '0) state_d = W_PC;
         W_PC:    if (out_ready) state_d = W_INST;
         W_INST:  if (out_ready) state_d = W_ALU;
         W_ALU:   if (out_ready) state_d = W_FLAGS;
         W_FLAGS: if (out_ready) state_d = (LAST_ST == W_FLAGS) ? next_rec : W_TS;
         W_TS:    if (out_ready) state_d = next_rec;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         level_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         seq_q      <= '0;
         pend_ovf_q <= 1'b0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         seq_q      <= seq_d;
         pend_ovf_q <= pend_ovf_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign seq16 = 16'(seq_mem[rd_ptr_q]);

   // Words come straight off the FIFO head, which only moves on the final handshake.
   always_comb begin
      out_data = '0;
      unique case (state_q)
         W_PC:    out_data = pc_mem[rd_ptr_q];
         W_INST:  out_data = inst_mem[rd_ptr_q];
         W_ALU:   out_data = alu_mem[rd_ptr_q];
         W_FLAGS: out_data = {seq16, 14'b0, povf_mem[rd_ptr_q], zero_mem[rd_ptr_q]};
         W_TS:    out_data = ts_word;
         default: out_data = '0;
      endcase
   end

   assign out_valid  = (state_q != IDLE);
   assign out_last   = (state_q == LAST_ST);
   assign fifo_level = level_q;
   assign drop_cnt   = drop_cnt_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: random stimulus checked each cycle against a record-queue model.
module tb_cpu_trace_buffer;

   localparam int DEPTH = 16;
   localparam int CNT_W = 16;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
   localparam int NW = 5;
`else
   localparam int NW = 4;
`endif
   localparam int VW = 2 + 32 + LW + CNT_W + 1;

   logic             clk, rst;
   logic             trace_en, trace_valid, trace_zero, clr_stats, out_ready;
   logic [31:0]      trace_pc, trace_inst, trace_alu;
   logic             out_valid, out_last, overflow;
   logic [31:0]      out_data;
   logic [LW-1:0]    fifo_level;
   logic [CNT_W-1:0] drop_cnt;

   int n_vec, n_bad;

   cpu_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .trace_en(trace_en), .trace_valid(trace_valid),
      .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_alu(trace_alu),
      .trace_zero(trace_zero), .clr_stats(clr_stats), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .fifo_level(fifo_level), .drop_cnt(drop_cnt), .overflow(overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] pc, inst, alu, ts;
      logic        zero, povf;
      logic [15:0] seq;
   } rec_t;

   // Model: queue of stored records plus the index of the word being offered.
   rec_t        mq[$];
   bit          m_busy, m_ovf, m_povf;
   int          m_widx;
   logic [15:0] m_drop, m_seq;
   logic [31:0] m_cyc;

   function automatic logic [31:0] word_of(rec_t r, int i);
      case (i)
         0:       return r.pc;
         1:       return r.inst;
         2:       return r.alu;
         3:       return {r.seq, 14'b0, r.povf, r.zero};
         default: return r.ts;
      endcase
   endfunction

   task automatic model_reset();
      mq.delete();
      m_busy = 0; m_widx = 0; m_ovf = 0; m_povf = 0;
      m_drop = '0; m_seq = '0; m_cyc = '0;
   endtask

   task automatic model_edge();
      int   pre;
      bit   hs, pop;
      rec_t r;
      pre = mq.size();
      hs  = m_busy && out_ready;
      pop = hs && (m_widx == NW - 1);
      if (hs) m_widx++;
      if (pop) begin
         mq.delete(0);
         m_widx = 0;
      end
      if (clr_stats) begin
         m_drop = '0;
         m_ovf  = 0;
      end
      if (trace_en && trace_valid) begin
         if (pre == DEPTH) begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            m_ovf  = 1;
            m_povf = 1;
         end else begin
            r.pc = trace_pc; r.inst = trace_inst; r.alu = trace_alu;
            r.zero = trace_zero; r.povf = m_povf; r.seq = m_seq; r.ts = m_cyc;
            mq.push_back(r);
            m_seq  = m_seq + 16'd1;
            m_povf = 0;
         end
      end
      if (!m_busy) m_busy = (pre > 0);
      else if (pop) m_busy = (mq.size() > 0);
      m_cyc = m_cyc + 32'd1;
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [31:0] d;
      logic        l;
      d = 32'd0;
      l = 1'b0;
      if (m_busy) begin
         d = word_of(mq[0], m_widx);
         l = (m_widx == NW - 1);
      end
      return {m_busy, l, d, LW'(mq.size()), m_drop, m_ovf};
   endfunction

   function automatic logic [VW-1:0] act_vec();
      return {out_valid, out_last, out_data, fifo_level, drop_cnt, overflow};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic rand_data();
      trace_pc   = $urandom();
      trace_inst = $urandom();
      trace_alu  = $urandom();
      trace_zero = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      trace_en = 0; trace_valid = 0; clr_stats = 0; out_ready = 0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      trace_en = 1; trace_valid = 1; out_ready = 1; clr_stats = 0;
      rand_data();
      repeat (3) @(negedge clk);
      model_reset();
      n_vec++;
      if (act_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL reset: got %h expected %h", act_vec(), exp_vec());
      end
      trace_en = 0; trace_valid = 0;
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [31:0] got[8];
      int ng, first_v, last_i;
      do_reset();
      ng = 0; first_v = -1; last_i = -1;
      out_ready = 1; trace_en = 1;
      trace_pc = 32'h0; trace_inst = 32'h20010005; trace_alu = 32'h5; trace_zero = 0;
      for (int i = 0; i < NW + 4; i++) begin
         trace_valid = (i == 0);
         tick();
         n_vec++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL single.cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
         if (out_valid && ng < 8) begin
            if (first_v < 0) first_v = i;
            if (out_last) last_i = ng;
            got[ng] = out_data;
            ng++;
         end
      end
      n_vec++;
      if (first_v !== 1 || ng !== NW || last_i !== 3 + (NW - 4)) begin
         n_bad++;
         $display("FAIL single.timing: got first=%0d words=%0d last=%0d expected 1 %0d %0d",
                  first_v, ng, last_i, NW, NW - 1);
      end
      n_vec++;
      if ({got[0], got[1], got[2], got[3]} !== {32'h0, 32'h20010005, 32'h5, 32'h0}) begin
         n_bad++;
         $display("FAIL single.words: got %h %h %h %h", got[0], got[1], got[2], got[3]);
      end
      n_vec++;
      if (fifo_level !== '0) begin
         n_bad++;
         $display("FAIL single.level: got %0d expected 0", fifo_level);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] seqs[3];
      int k, ns, run;
      bit ended;
      do_reset();
      k = 0; ns = 0; run = 0; ended = 0;
      out_ready = 1; trace_en = 1;
      for (int i = 0; i < 3 * NW + 6; i++) begin
         trace_valid = (i < 3);
         rand_data();
         tick();
         n_vec++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL b2b.cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
         if (out_valid && !ended) run++;
         else if (run > 0) ended = 1;
         if (out_valid) begin
            if (k % NW == 3 && ns < 3) begin
               seqs[ns] = out_data[31:16];
               ns++;
            end
            k++;
         end
      end
      n_vec++;
      if (run !== 3 * NW) begin
         n_bad++;
         $display("FAIL b2b.run: got %0d contiguous words expected %0d", run, 3 * NW);
      end
      n_vec++;
      if (ns !== 3 || {seqs[0], seqs[1], seqs[2]} !== {16'd0, 16'd1, 16'd2}) begin
         n_bad++;
         $display("FAIL b2b.seq: got n=%0d %0d %0d %0d expected 0 1 2", ns, seqs[0], seqs[1], seqs[2]);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] flags[20];
      int k, nr;
      do_reset();
      out_ready = 0; trace_en = 1; trace_valid = 1;
      for (int i = 0; i < 18; i++) begin
         rand_data();
         tick();
         n_vec++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL ovf.fill%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
      end
      trace_valid = 0;
      n_vec++;
      if ({fifo_level, drop_cnt, overflow} !== {5'd16, 16'd2, 1'b1}) begin
         n_bad++;
         $display("FAIL ovf.stats: got lvl=%0d drop=%0d ovf=%0d expected 16 2 1",
                  fifo_level, drop_cnt, overflow);
      end
      out_ready = 1; k = 0; nr = 0;
      for (int i = 0; i < 17 * NW + 8; i++) begin
         trace_valid = (i == 16 * NW + 2);
         rand_data();
         if (out_valid) begin
            if (k % NW == 3 && nr < 20) begin
               flags[nr] = out_data;
               nr++;
            end
            k++;
         end
         tick();
         n_vec++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL ovf.drain%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
      end
      n_vec++;
      if (nr !== 17 || flags[15][1] !== 1'b0 || flags[16][1] !== 1'b1 || flags[16][31:16] !== 16'd16) begin
         n_bad++;
         $display("FAIL ovf.flags: got n=%0d f15=%h f16=%h expected 17 bit1 0/1 seq16",
                  nr, flags[15], flags[16]);
      end
   endtask

   task automatic test_stall_random();
      logic [VW-1:0] prev;
      logic          prev_rdy;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         trace_en    = ($urandom_range(0, 7) != 0);
         trace_valid = 1'($urandom_range(0, 1));
         clr_stats   = ($urandom_range(0, 31) == 0);
         out_ready   = 1'($urandom_range(0, 1));
         rand_data();
         prev     = act_vec();
         prev_rdy = out_ready;
         tick();
         n_vec++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL stall.cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
         if (prev[VW-1] && !prev_rdy) begin
            n_vec++;
            if ({out_valid, out_last, out_data} !== prev[VW-1 -: 34]) begin
               n_bad++;
               $display("FAIL stall.hold%0d: got %h expected %h", i,
                        {out_valid, out_last, out_data}, prev[VW-1 -: 34]);
            end
         end
      end
      clr_stats = 0;
   endtask

   task automatic test_full_pushpop();
      do_reset();
      out_ready = 0; trace_en = 1; trace_valid = 1;
      for (int i = 0; i < DEPTH; i++) begin
         rand_data();
         tick();
      end
      trace_valid = 0; out_ready = 1;
      for (int i = 0; i < NW - 1; i++) begin
         tick();
         n_vec++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL full.adv%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
      end
      trace_valid = 1;
      rand_data();
      tick();
      trace_valid = 0;
      n_vec++;
      if ({fifo_level, drop_cnt, overflow} !== {5'd15, 16'd1, 1'b1}) begin
         n_bad++;
         $display("FAIL full.pushpop: got lvl=%0d drop=%0d ovf=%0d expected 15 1 1",
                  fifo_level, drop_cnt, overflow);
      end
      out_ready = 0; clr_stats = 1;
      tick();
      clr_stats = 0;
      n_vec++;
      if ({fifo_level, drop_cnt, overflow} !== {5'd15, 16'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL full.clr: got lvl=%0d drop=%0d ovf=%0d expected 15 0 0",
                  fifo_level, drop_cnt, overflow);
      end
      trace_valid = 1;
      rand_data();
      tick();
      clr_stats = 1;
      rand_data();
      tick();
      clr_stats = 0; trace_valid = 0;
      n_vec++;
      if ({fifo_level, drop_cnt, overflow} !== {5'd16, 16'd1, 1'b1}) begin
         n_bad++;
         $display("FAIL full.clr_drop: got lvl=%0d drop=%0d ovf=%0d expected 16 1 1",
                  fifo_level, drop_cnt, overflow);
      end
      n_vec++;
      if (act_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL full.end: got %h expected %h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_reset_midburst();
      logic [31:0] got[8];
      int ng, ncyc;
      do_reset();
      out_ready = 1; trace_en = 1; trace_valid = 1;
      rand_data();
      tick();
      trace_valid = 0;
      tick();
      tick();
      n_vec++;
      if (act_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL rstmid.pre: got %h expected %h", act_vec(), exp_vec());
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if ({out_valid, out_last, out_data, fifo_level} !== '0) begin
         n_bad++;
         $display("FAIL rstmid.async: got v=%0d l=%0d d=%h lvl=%0d expected all 0",
                  out_valid, out_last, out_data, fifo_level);
      end
      @(negedge clk);
      model_reset();
      rst = 1'b0;
      ncyc = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         ncyc++;
         n_vec++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstmid.idle%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
      end
      trace_valid = 1;
      rand_data();
      tick();
      trace_valid = 0;
      ng = 0;
      for (int i = 0; i < NW + 3; i++) begin
         tick();
         n_vec++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstmid.rec%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
         if (out_valid && ng < 8) begin
            got[ng] = out_data;
            ng++;
         end
      end
      n_vec++;
      if (ng !== NW || got[3][31:16] !== 16'd0) begin
         n_bad++;
         $display("FAIL rstmid.seq: got n=%0d flags=%h expected %0d words seq 0", ng, got[3], NW);
      end
`ifdef TRACE_TIMESTAMP_EN
      n_vec++;
      if (got[4] !== 32'(ncyc)) begin
         n_bad++;
         $display("FAIL rstmid.ts: got %0d expected %0d", got[4], ncyc);
      end
`endif
   endtask

   initial begin
      n_vec = 0; n_bad = 0;
      rst = 1'b1;
      trace_en = 0; trace_valid = 0; clr_stats = 0; out_ready = 0;
      trace_pc = '0; trace_inst = '0; trace_alu = '0; trace_zero = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_stall_random();
      test_full_pushpop();
      test_reset_midburst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
